// File: rtl/instr_mem_responder.sv
// instr_mem_responder
// Instruction memory for the fetch stage. It returns a registered 32-bit word one cycle after the
// next-PC address and honours the decode stall/clear controls. A byte-serial loader FSM fills the
// word array from a host byte stream, and fetch is blanked while a load is active.
//
// Optional build macro: IMEM_MISALIGN_TRAP_EN
//   defined   - a fetch with addr[1:0] != 0 returns CLEAR_WORD and raises fetch_misalign.
//   undefined - addr[1:0] is ignored, so a misaligned fetch reads the containing word.
//               fetch_misalign is tied low.
module instr_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] CLEAR_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] if_pc_next_instr_mem,
    input  logic        de_stall,
    input  logic        de_clear,
    output logic [31:0] if_instr_rd,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        ld_done,
    output logic        ld_overflow,
    output logic        fetch_misalign
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    // First byte address past the end of the array. The extra bit keeps the compare from wrapping.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0] LAST_WPTR = AW'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_COMMIT,
        S_DONE
    } ld_state_t;

    ld_state_t state;
    ld_state_t state_nxt;

    // Loader datapath
    logic [AW-1:0] wptr;
    logic [1:0]    bidx;
    logic [31:0]   assembly;
    logic          last_seen;

    // Strobes decoded by the FSM for the loader datapath
    logic start_load;
    logic byte_accept;
    logic commit_we;
    logic advance_word;
    logic set_overflow;

    // Word storage. It is deliberately not reset, so an image survives reset_n.
    logic [31:0] mem [DEPTH_WORDS];

    // Fetch address decode
    logic [AW-1:0] fetch_idx;
    logic          fetch_oob;

    assign fetch_idx = if_pc_next_instr_mem[AW+1:2];
    assign fetch_oob = {1'b0, if_pc_next_instr_mem} >= ADDR_LIMIT;

    // Loader state register. Reset drops any load in progress straight back to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Loader next-state logic, handshake outputs and datapath strobes
    always_comb begin
        state_nxt    = state;
        ld_ready     = 1'b0;
        ld_busy      = 1'b0;
        ld_done      = 1'b0;
        start_load   = 1'b0;
        byte_accept  = 1'b0;
        commit_we    = 1'b0;
        advance_word = 1'b0;
        set_overflow = 1'b0;
        case (state)
            S_IDLE: begin
                if (ld_start) begin
                    start_load = 1'b1;
                    state_nxt  = S_RECV;
                end
            end
            S_RECV: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (ld_valid) begin
                    byte_accept = 1'b1;
                    if ((bidx == 2'd3) || ld_last) begin
                        state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                ld_busy   = 1'b1;
                commit_we = 1'b1;
                if (last_seen) begin
                    state_nxt = S_DONE;
                end else if (wptr == LAST_WPTR) begin
                    // The array is full but the image has not ended. Flag it and stop
                    // accepting bytes.
                    set_overflow = 1'b1;
                    state_nxt    = S_DONE;
                end else begin
                    advance_word = 1'b1;
                    state_nxt    = S_RECV;
                end
            end
            S_DONE: begin
                ld_busy   = 1'b1;
                ld_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Loader datapath: word pointer, byte index, little-endian word assembly and overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            bidx        <= 2'd0;
            assembly    <= 32'h0;
            last_seen   <= 1'b0;
            ld_overflow <= 1'b0;
        end else begin
            if (start_load) begin
                wptr        <= '0;
                bidx        <= 2'd0;
                assembly    <= 32'h0;
                last_seen   <= 1'b0;
                ld_overflow <= 1'b0;
            end
            if (byte_accept) begin
                assembly[{bidx, 3'b000} +: 8] <= ld_byte;
                bidx                          <= bidx + 2'd1;
                last_seen                     <= ld_last;
            end
            if (advance_word) begin
                wptr     <= wptr + AW'(1);
                bidx     <= 2'd0;
                assembly <= 32'h0;
            end
            if (set_overflow) begin
                ld_overflow <= 1'b1;
            end
        end
    end

    // Array write port. It only writes on a loader commit, and bytes not yet filled stay zero.
    always_ff @(posedge clk) begin
        if (commit_we) begin
            mem[wptr] <= assembly;
        end
    end

`ifdef IMEM_MISALIGN_TRAP_EN
    logic misalign_now;
    logic misalign_q;

    assign misalign_now = |if_pc_next_instr_mem[1:0];

    // Fetch register. Priority is clear, then stall, then loader blanking, then range or
    // alignment, then the read. The misalign flag follows the same clear/stall/hold rules
    // as the data word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_instr_rd <= CLEAR_WORD;
            misalign_q  <= 1'b0;
        end else if (de_clear) begin
            if_instr_rd <= CLEAR_WORD;
            misalign_q  <= 1'b0;
        end else if (!de_stall) begin
            if (ld_busy) begin
                if_instr_rd <= CLEAR_WORD;
            end else begin
                misalign_q <= misalign_now;
                if (fetch_oob || misalign_now) begin
                    if_instr_rd <= CLEAR_WORD;
                end else begin
                    if_instr_rd <= mem[fetch_idx];
                end
            end
        end
    end

    assign fetch_misalign = misalign_q;
`else
    // The low address bits are not used in this build, because misaligned fetches read the
    // containing word.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^if_pc_next_instr_mem[1:0];

    // Fetch register. Priority is clear, then stall, then loader blanking, then out-of-range,
    // then the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_instr_rd <= CLEAR_WORD;
        end else if (de_clear) begin
            if_instr_rd <= CLEAR_WORD;
        end else if (!de_stall) begin
            if (ld_busy || fetch_oob) begin
                if_instr_rd <= CLEAR_WORD;
            end else begin
                if_instr_rd <= mem[fetch_idx];
            end
        end
    end

    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Testbench for instr_mem_responder. It runs a small array (4 words) so overflow is reachable,
// and uses a scoreboard queue of expected fetch results.
module tb_instr_mem_responder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] CLR   = 32'h0000_0000;
`ifdef IMEM_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] addr;
    logic        de_stall;
    logic        de_clear;
    logic [31:0] if_instr_rd;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_overflow;
    logic        fetch_misalign;

    instr_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .CLEAR_WORD (CLR)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .if_pc_next_instr_mem(addr),
        .de_stall            (de_stall),
        .de_clear            (de_clear),
        .if_instr_rd         (if_instr_rd),
        .ld_start            (ld_start),
        .ld_valid            (ld_valid),
        .ld_byte             (ld_byte),
        .ld_last             (ld_last),
        .ld_ready            (ld_ready),
        .ld_busy             (ld_busy),
        .ld_done             (ld_done),
        .ld_overflow         (ld_overflow),
        .fetch_misalign      (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] img [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] data, input logic mis);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.mis  = mis;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        asserts++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL sb_empty: observed %0d entries expected >0", exp_q.size());
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk(e.tag, if_instr_rd, e.data);
        chk({e.tag, "_mis"}, {31'b0, fetch_misalign}, {31'b0, e.mis});
    endtask

    // Drive one fetch on a falling edge and check the registered result one cycle later.
    task automatic fetch(input logic [31:0] a, input logic stall, input logic clr,
                         input logic [31:0] e, input logic m, input string tag);
        @(negedge clk);
        addr     = a;
        de_stall = stall;
        de_clear = clr;
        expect_fetch(tag, e, m);
        @(negedge clk);
        check_out();
    endtask

    task automatic start_load();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Offer img[0..n-1] once every 'period' cycles. A byte is accepted when ld_ready is high
    // while it is presented. The task counts accepts and ld_done pulses, and checks that the
    // fetch after DONE is blanked.
    task automatic stream(input int n, input bit use_last, input int period, input int budget,
                          output int acc, output int dones);
        bit pend;
        acc   = 0;
        dones = 0;
        pend  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (pend) begin
                check_out();
                pend = 1'b0;
            end
            if (ld_done) begin
                dones++;
                expect_fetch("fetch_leaving_done", CLR, 1'b0);
                pend = 1'b1;
            end
            if ((acc < n) && ((c % period) == 0)) begin
                ld_valid = 1'b1;
                ld_byte  = img[acc];
                ld_last  = use_last && (acc == n - 1);
                if (ld_ready) acc++;
            end else begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic set_prog();
        img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h00;
        img[4] = 8'h93; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int dones;
        int ndone;

        reset_n  = 1'b0;
        addr     = 32'h0;
        de_stall = 1'b0;
        de_clear = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        ld_last  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd", if_instr_rd, CLR);
        chk("rst_ready", {31'b0, ld_ready}, 32'd0);
        chk("rst_busy", {31'b0, ld_busy}, 32'd0);
        chk("rst_done", {31'b0, ld_done}, 32'd0);
        chk("rst_ovf", {31'b0, ld_overflow}, 32'd0);
        chk("rst_mis", {31'b0, fetch_misalign}, 32'd0);
        reset_n = 1'b1;

        // Two-word program with ld_last on byte 8
        set_prog();
        start_load();
        chk("prog_busy_start", {31'b0, ld_busy}, 32'd1);
        stream(8, 1'b1, 1, 20, acc, dones);
        chk("prog_acc", acc, 32'd8);
        chk("prog_dones", dones, 32'd1);
        chk("prog_ovf", {31'b0, ld_overflow}, 32'd0);
        chk("prog_busy_end", {31'b0, ld_busy}, 32'd0);
        fetch(32'h0, 1'b0, 1'b0, 32'h00500013, 1'b0, "prog_w0");
        fetch(32'h4, 1'b0, 1'b0, 32'h00100093, 1'b0, "prog_w1");

        // Partial last word: AA BB CC DD EE
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD; img[4] = 8'hEE;
        start_load();
        stream(5, 1'b1, 1, 20, acc, dones);
        chk("part_acc", acc, 32'd5);
        chk("part_dones", dones, 32'd1);
        fetch(32'h0, 1'b0, 1'b0, 32'hDDCCBBAA, 1'b0, "part_w0");
        fetch(32'h4, 1'b0, 1'b0, 32'h000000EE, 1'b0, "part_w1");

        // Same program again with ld_valid throttled to 1 of 3 cycles
        set_prog();
        start_load();
        stream(8, 1'b1, 3, 60, acc, dones);
        chk("thr_acc", acc, 32'd8);
        chk("thr_dones", dones, 32'd1);
        fetch(32'h0, 1'b0, 1'b0, 32'h00500013, 1'b0, "thr_w0");
        fetch(32'h4, 1'b0, 1'b0, 32'h00100093, 1'b0, "thr_w1");

        // Stall holds the output while the address changes, and clear beats stall
        fetch(32'h4, 1'b0, 1'b0, 32'h00100093, 1'b0, "stall_pre");
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0, 1'b1, 1'b0, 32'h00100093, 1'b0, "stall_hold");
        end
        fetch(32'h0, 1'b1, 1'b1, CLR, 1'b0, "stall_and_clear");
        fetch(32'h0, 1'b0, 1'b0, 32'h00500013, 1'b0, "after_clear");

        // Overflow: 20 bytes offered without ld_last into 4 words
        for (int i = 0; i < 20; i++) img[i] = 8'(i);
        start_load();
        stream(20, 1'b0, 1, 40, acc, dones);
        chk("ovf_acc", acc, 32'd16);
        chk("ovf_dones", dones, 32'd1);
        chk("ovf_flag", {31'b0, ld_overflow}, 32'd1);
        fetch(32'h0, 1'b0, 1'b0, 32'h03020100, 1'b0, "ovf_w0");
        fetch(32'hC, 1'b0, 1'b0, 32'h0F0E0D0C, 1'b0, "ovf_w3");
        fetch(32'h10, 1'b0, 1'b0, CLR, 1'b0, "oob_0x10");
        fetch(32'hFFFF_FFFC, 1'b0, 1'b0, CLR, 1'b0, "oob_top");

        // A new load clears the overflow flag. Reset it after 6 bytes.
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33;
        img[3] = 8'h44; img[4] = 8'h55; img[5] = 8'h66;
        start_load();
        chk("ovf_cleared", {31'b0, ld_overflow}, 32'd0);
        stream(6, 1'b0, 1, 10, acc, dones);
        chk("mid_acc", acc, 32'd6);
        chk("mid_dones", dones, 32'd0);
        chk("mid_busy", {31'b0, ld_busy}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_busy", {31'b0, ld_busy}, 32'd0);
        chk("async_ready", {31'b0, ld_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ld_done) ndone++;
        end
        chk("mid_no_done", ndone, 32'd0);
        chk("mid_idle", {31'b0, ld_busy}, 32'd0);
        fetch(32'h0, 1'b0, 1'b0, 32'h44332211, 1'b0, "mid_w0_kept");
        fetch(32'h4, 1'b0, 1'b0, 32'h07060504, 1'b0, "mid_w1_old");

        // Misaligned fetch
        if (MIS_EN) begin
            fetch(32'h2, 1'b0, 1'b0, CLR, 1'b1, "misalign_trap");
        end else begin
            fetch(32'h2, 1'b0, 1'b0, 32'h44332211, 1'b0, "misalign_word");
        end
        fetch(32'h0, 1'b0, 1'b0, 32'h44332211, 1'b0, "aligned_after");

        // Asynchronous reset while the output holds a nonzero word
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd", if_instr_rd, CLR);
        chk("async_mis", {31'b0, fetch_misalign}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
